// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one single-port SRAM between the deinterleaver stream,
// which has absolute priority, and a host request port that waits for a free
// cycle. The stream path is a combinational pass-through. The host path is a
// small FSM with a saturating wait counter and a sticky starvation flag.
//
// Build option: define SRAM_ARB_HOST_WRITE_EN to let host writes reach the
// SRAM. Without it, a host write is accepted and then dropped without any
// SRAM access.
//
// state | meaning
// IDLE  | h_ready=1, waiting for a host request
// PEND  | host request captured, waiting for a cycle with d_nce=1
// RDATA | host read data present on s_do, h_rvalid=1 for one cycle
module sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst,
  // deinterleaver stream port
  input  logic [13:0] d_addr,
  input  logic        d_nce,
  input  logic        d_nwrt,
  input  logic [10:0] d_din,
  output logic [10:0] d_dout,
  output logic        d_valid,
  // host port
  input  logic        h_req,
  input  logic        h_wr,
  input  logic [13:0] h_addr,
  input  logic [10:0] h_wdata,
  output logic        h_ready,
  output logic [10:0] h_rdata,
  output logic        h_rvalid,
  output logic        h_starved,
  // SRAM port
  output logic [13:0] s_addr,
  output logic        s_nce,
  output logic        s_nwrt,
  output logic [10:0] s_din,
  input  logic [10:0] s_do
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    RDATA = 2'd2
  } state_t;

`ifdef SRAM_ARB_HOST_WRITE_EN
  localparam logic HOST_WR_EN = 1'b1;
`else
  localparam logic HOST_WR_EN = 1'b0;
`endif

  localparam logic [8:0] STARVE_TC = 9'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic        req_wr_q, req_wr_d;
  logic [13:0] req_addr_q, req_addr_d;
  logic [10:0] req_wdata_q, req_wdata_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        starved_q, starved_d;
  logic        d_valid_q, d_valid_d;
  logic [13:0] hold_addr_q, hold_addr_d;
  logic [10:0] hold_din_q, hold_din_d;
  logic        host_go;
  logic        starve_now;

  // Host FSM next state, request capture, wait counter and host grant.
  always_comb begin
    state_d     = state_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    wait_cnt_d  = wait_cnt_q;
    host_go     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (h_req) begin
          state_d     = PEND;
          req_wr_d    = h_wr;
          req_addr_d  = h_addr;
          req_wdata_d = h_wdata;
          wait_cnt_d  = 8'd0;
        end
      end
      PEND: begin
        if (wait_cnt_q != 8'hFF) begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
        if (req_wr_q && !HOST_WR_EN) begin
          // dropped write: leave without touching the SRAM
          state_d = IDLE;
        end else if (d_nce) begin
          host_go = 1'b1;
          state_d = req_wr_q ? IDLE : RDATA;
        end
      end
      RDATA: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // a pending request is discarded by reset and never reaches the SRAM
    if (rst) begin
      state_d    = IDLE;
      wait_cnt_d = 8'd0;
      host_go    = 1'b0;
    end
  end

  // Starvation: the current PEND cycle is the STARVE_LIMIT-th one; flag is sticky.
  always_comb begin
    starve_now = (state_q == PEND) && !rst &&
                 (({1'b0, wait_cnt_q} + 9'd1) == STARVE_TC);
    starved_d  = rst ? 1'b0 : (starved_q | starve_now);
    d_valid_d  = !rst && !d_nce && d_nwrt;
  end

  // SRAM port mux: stream first, then host grant, otherwise idle with held address/data.
  always_comb begin
    s_addr = hold_addr_q;
    s_din  = hold_din_q;
    s_nce  = 1'b1;
    s_nwrt = 1'b1;
    if (!d_nce) begin
      s_addr = d_addr;
      s_din  = d_din;
      s_nce  = 1'b0;
      s_nwrt = d_nwrt;
    end else if (host_go) begin
      s_addr = req_addr_q;
      s_din  = req_wdata_q;
      s_nce  = 1'b0;
      s_nwrt = ~(req_wr_q & HOST_WR_EN);
    end
    hold_addr_d = s_addr;
    hold_din_d  = s_din;
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= 8'd0;
      starved_q  <= 1'b0;
      d_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
      d_valid_q  <= d_valid_d;
    end
  end

  // Datapath registers; the held SRAM address/data keep tracking the stream during reset.
  always_ff @(posedge clk) begin
    req_wr_q    <= req_wr_d;
    req_addr_q  <= req_addr_d;
    req_wdata_q <= req_wdata_d;
    hold_addr_q <= hold_addr_d;
    hold_din_q  <= hold_din_d;
  end

  assign d_valid   = d_valid_q;
  assign d_dout    = s_do;
  assign h_ready   = (state_q == IDLE);
  assign h_rvalid  = (state_q == RDATA);
  assign h_rdata   = s_do;
  assign h_starved = starved_q | starve_now;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random stimulus for sram_arbiter against a
// transaction-level model (golden memory, pending host request, expected
// read returns). Honours SRAM_ARB_HOST_WRITE_EN the same way as the design.
module tb_sram_arbiter;
  localparam int LIMIT = 12;

`ifdef SRAM_ARB_HOST_WRITE_EN
  localparam bit HOST_WR_EN = 1'b1;
`else
  localparam bit HOST_WR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] d_addr;
  logic        d_nce, d_nwrt;
  logic [10:0] d_din, d_dout;
  logic        d_valid;
  logic        h_req, h_wr;
  logic [13:0] h_addr;
  logic [10:0] h_wdata, h_rdata;
  logic        h_ready, h_rvalid, h_starved;
  logic [13:0] s_addr;
  logic        s_nce, s_nwrt;
  logic [10:0] s_din;
  logic [10:0] s_do;

  always #5 clk = ~clk;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .d_addr(d_addr), .d_nce(d_nce), .d_nwrt(d_nwrt), .d_din(d_din),
    .d_dout(d_dout), .d_valid(d_valid),
    .h_req(h_req), .h_wr(h_wr), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_ready(h_ready), .h_rdata(h_rdata), .h_rvalid(h_rvalid), .h_starved(h_starved),
    .s_addr(s_addr), .s_nce(s_nce), .s_nwrt(s_nwrt), .s_din(s_din), .s_do(s_do)
  );

  // SRAM device: read data appears on s_do one cycle after the access edge
  logic [10:0] sram_mem [0:16383];
  always @(posedge clk) begin
    if (!s_nce) begin
      if (!s_nwrt) sram_mem[s_addr] <= s_din;
      else         s_do <= sram_mem[s_addr];
    end
  end

  // reference model state
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;
  logic [10:0] gold [0:16383];
  bit          pending = 0, rdata_due = 0, dvalid_due = 0, starved_exp = 0, have_last = 0;
  bit          cap_wr;
  logic [13:0] cap_addr;
  logic [10:0] cap_data;
  int          pend_cycles = 0;
  logic [10:0] rdata_exp, dout_exp;
  logic [13:0] last_addr;
  logic [10:0] last_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock cycle: drive, check at negedge, advance the model, move past the next edge
  task automatic cyc(input bit r, input bit dn, input bit dw, input logic [13:0] da,
                     input logic [10:0] dd, input bit hq, input bit hw,
                     input logic [13:0] ha, input logic [10:0] hd);
    bit idle, grant;
    rst = r; d_nce = dn; d_nwrt = dw; d_addr = da; d_din = dd;
    h_req = hq; h_wr = hw; h_addr = ha; h_wdata = hd;
    @(negedge clk);
    idle  = !pending && !rdata_due;
    grant = pending && d_nce && !rst && (!cap_wr || HOST_WR_EN);
    if (pending && !rst) begin
      pend_cycles++;
      if (pend_cycles >= LIMIT) starved_exp = 1'b1;
    end
    if (chk_en) begin
      chk("h_ready", h_ready, idle);
      chk("h_rvalid", h_rvalid, rdata_due);
      if (rdata_due) chk("h_rdata", h_rdata, rdata_exp);
      chk("d_valid", d_valid, dvalid_due);
      if (dvalid_due) chk("d_dout", d_dout, dout_exp);
      chk("both_valid", d_valid & h_rvalid, 1'b0);
      chk("h_starved", h_starved, starved_exp);
      if (!d_nce) begin
        chk("pass_nce", s_nce, 1'b0);
        chk("pass_addr", s_addr, d_addr);
        chk("pass_nwrt", s_nwrt, d_nwrt);
        chk("pass_din", s_din, d_din);
      end else if (grant) begin
        chk("host_nce", s_nce, 1'b0);
        chk("host_addr", s_addr, cap_addr);
        chk("host_nwrt", s_nwrt, !cap_wr);
        chk("host_din", s_din, cap_data);
      end else begin
        chk("idle_nce", s_nce, 1'b1);
        chk("idle_nwrt", s_nwrt, 1'b1);
        if (have_last) begin
          chk("hold_addr", s_addr, last_addr);
          chk("hold_din", s_din, last_din);
        end
      end
    end
    // advance the model to the next cycle
    dvalid_due = !rst && !d_nce && d_nwrt;
    if (!d_nce) begin
      if (d_nwrt) dout_exp = gold[d_addr];
      else        gold[d_addr] = d_din;
      have_last = 1'b1; last_addr = d_addr; last_din = d_din;
    end else if (grant) begin
      have_last = 1'b1; last_addr = cap_addr; last_din = cap_data;
      if (cap_wr) gold[cap_addr] = cap_data;
      else        rdata_exp = gold[cap_addr];
    end
    if (rst) begin
      pending = 0; rdata_due = 0; starved_exp = 0; pend_cycles = 0;
    end else begin
      rdata_due = grant && !cap_wr;
      if (pending) begin
        if (grant || (cap_wr && !HOST_WR_EN)) pending = 0;
      end else if (idle && h_req) begin
        pending = 1; cap_wr = h_wr; cap_addr = h_addr; cap_data = h_wdata; pend_cycles = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] raddr();
    case ($urandom % 4)
      0:       return 14'h3FFF;
      1:       return 14'h0100;
      default: return 14'($urandom % 8);
    endcase
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(0, 1, 1, 14'h0, 11'h0, 0, 0, 14'h0, 11'h0);
  endtask

  // stream traffic while the host waits; h_req toggles randomly and must be ignored
  task automatic blocked_cycles(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 1'($urandom % 2), raddr(), 11'($urandom), 1'($urandom % 2), 1'($urandom % 2),
          raddr(), 11'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      logic [10:0] v;
      v = 11'($urandom);
      sram_mem[i] = v;
      gold[i] = v;
    end
    // reset; first cycle unchecked since the design is still unknown
    cyc(1, 1, 1, 14'h0, 11'h0, 0, 0, 14'h0, 11'h0);
    chk_en = 1'b1;
    cyc(1, 1, 1, 14'h0, 11'h0, 1, 0, 14'h5, 11'h0);
    idle_cycles(2);

    // stream write then read of 0x0012
    cyc(0, 0, 0, 14'h0012, 11'h155, 0, 0, 14'h0, 11'h0);
    cyc(0, 0, 1, 14'h0012, 11'h000, 0, 0, 14'h0, 11'h0);
    idle_cycles(2);

    // host read of 0x3FFF holding 0x7FF, stream idle
    cyc(0, 0, 0, 14'h3FFF, 11'h7FF, 0, 0, 14'h0, 11'h0);
    cyc(0, 1, 1, 14'h0, 11'h0, 1, 0, 14'h3FFF, 11'h0);
    idle_cycles(3);

    // host read blocked by 10 stream cycles, no starvation
    cyc(0, 1, 1, 14'h0, 11'h0, 1, 0, 14'h0012, 11'h0);
    blocked_cycles(10);
    idle_cycles(3);

    // host read blocked long enough to starve; flag stays set
    cyc(0, 1, 1, 14'h0, 11'h0, 1, 0, 14'h0003, 11'h0);
    blocked_cycles(LIMIT + 2);
    idle_cycles(4);

    // host write then read of 0x0100
    cyc(0, 1, 1, 14'h0, 11'h0, 1, 1, 14'h0100, 11'h0AA);
    idle_cycles(2);
    cyc(0, 1, 1, 14'h0, 11'h0, 1, 0, 14'h0100, 11'h0);
    idle_cycles(3);

    // reset while a host read is pending, with stream pass-through active during reset
    cyc(0, 1, 1, 14'h0, 11'h0, 1, 0, 14'h0007, 11'h0);
    blocked_cycles(2);
    cyc(1, 1, 1, 14'h0, 11'h0, 0, 0, 14'h0, 11'h0);
    cyc(1, 0, 0, 14'h0006, 11'h3C3, 1, 0, 14'h0006, 11'h0);
    idle_cycles(3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 256) == 0, 1'($urandom % 2), 1'($urandom % 2), raddr(), 11'($urandom),
          ($urandom % 5) < 2, 1'($urandom % 2), raddr(), 11'($urandom));
    end
    idle_cycles(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
